// File: rtl/gyro_axis_conditioner.sv
// Gyro axis conditioner: calibrates a per-axis zero-rate bias, removes it, deadbands the rate and
// integrates it into per-axis angles. Define GYRO_ANGLE_WRAP_EN for wrap-around angles instead of saturation.
module gyro_axis_conditioner #(
  parameter int CAL_LOG2 = 6,
  parameter int DEADBAND = 4,
  parameter int ANGLE_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_valid,
  input  logic signed [15:0]        x_in,
  input  logic signed [15:0]        y_in,
  input  logic signed [15:0]        z_in,
  input  logic                      recal,
  input  logic                      angle_clr,
  output logic                      cal_done,
  output logic                      out_valid,
  output logic signed [15:0]        x_rate,
  output logic signed [15:0]        y_rate,
  output logic signed [15:0]        z_rate,
  output logic signed [ANGLE_W-1:0] x_angle,
  output logic signed [ANGLE_W-1:0] y_angle,
  output logic signed [ANGLE_W-1:0] z_angle
);

  localparam int SW = 16 + CAL_LOG2;
  localparam logic [CAL_LOG2-1:0]      CNT_LAST  = '1;
  localparam logic signed [16:0]       DB_POS    = 17'(DEADBAND);
  localparam logic signed [16:0]       DB_NEG    = -DB_POS;
  localparam logic signed [ANGLE_W-1:0] ANGLE_MAX = {1'b0, {(ANGLE_W-1){1'b1}}};
  localparam logic signed [ANGLE_W-1:0] ANGLE_MIN = {1'b1, {(ANGLE_W-1){1'b0}}};

  typedef enum logic {ST_CAL, ST_RUN} state_e;

  state_e                     state_q, state_d;
  logic [CAL_LOG2-1:0]        cnt_q, cnt_d;
  logic signed [SW-1:0]       sum_q [3];
  logic signed [SW-1:0]       sum_d [3];
  logic signed [SW-1:0]       cal_sum [3];
  logic signed [15:0]         bias_q [3];
  logic signed [15:0]         bias_d [3];
  logic signed [15:0]         rate_q [3];
  logic signed [15:0]         rate_d [3];
  logic signed [ANGLE_W-1:0]  angle_q [3];
  logic signed [ANGLE_W-1:0]  angle_d [3];
  logic signed [ANGLE_W-1:0]  angle_acc [3];
  logic signed [15:0]         smp [3];
  logic                       out_valid_q, out_valid_d;

  assign smp[0] = x_in;
  assign smp[1] = y_in;
  assign smp[2] = z_in;

  // Bias-removed rate, clamped to 16 bits, then zeroed inside the deadband.
  function automatic logic signed [15:0] condition(input logic signed [15:0] s,
                                                   input logic signed [15:0] b);
    logic signed [16:0] diff;
    logic signed [15:0] sat;
    diff = {s[15], s} - {b[15], b};
    if (diff[16] != diff[15]) begin
      sat = diff[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      sat = diff[15:0];
    end
    if (($signed({sat[15], sat}) <= DB_POS) && ($signed({sat[15], sat}) >= DB_NEG)) begin
      return 16'sd0;
    end else begin
      return sat;
    end
  endfunction

  function automatic logic signed [ANGLE_W-1:0] accumulate(input logic signed [ANGLE_W-1:0] a,
                                                            input logic signed [15:0] r);
`ifdef GYRO_ANGLE_WRAP_EN
    return a + {{(ANGLE_W-16){r[15]}}, r};
`else
    logic signed [ANGLE_W:0] s;
    s = {a[ANGLE_W-1], a} + {{(ANGLE_W-15){r[15]}}, r};
    if (s[ANGLE_W] != s[ANGLE_W-1]) begin
      return s[ANGLE_W] ? ANGLE_MIN : ANGLE_MAX;
    end else begin
      return s[ANGLE_W-1:0];
    end
`endif
  endfunction

  // Next-state: recal beats a coincident sample; angle_clr overrides any accumulation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    bias_d      = bias_q;
    rate_d      = rate_q;
    angle_acc   = angle_q;
    out_valid_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cal_sum[i] = sum_q[i] + {{CAL_LOG2{smp[i][15]}}, smp[i]};
    end
    if (recal) begin
      state_d = ST_CAL;
      cnt_d   = '0;
      for (int i = 0; i < 3; i++) sum_d[i] = '0;
    end else if (sample_valid) begin
      case (state_q)
        ST_CAL: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            for (int i = 0; i < 3; i++) begin
              bias_d[i] = cal_sum[i][CAL_LOG2 +: 16];
              sum_d[i]  = '0;
            end
          end else begin
            cnt_d = cnt_q + CAL_LOG2'(1);
            for (int i = 0; i < 3; i++) sum_d[i] = cal_sum[i];
          end
        end
        ST_RUN: begin
          out_valid_d = 1'b1;
          for (int i = 0; i < 3; i++) begin
            rate_d[i]    = condition(smp[i], bias_q[i]);
            angle_acc[i] = accumulate(angle_q[i], rate_d[i]);
          end
        end
        default: state_d = ST_CAL;
      endcase
    end else begin
      out_valid_d = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      angle_d[i] = angle_clr ? '0 : angle_acc[i];
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_CAL;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        sum_q[i]   <= '0;
        bias_q[i]  <= '0;
        rate_q[i]  <= '0;
        angle_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      bias_q      <= bias_d;
      rate_q      <= rate_d;
      angle_q     <= angle_d;
    end
  end

  assign cal_done  = (state_q == ST_RUN);
  assign out_valid = out_valid_q;
  assign x_rate    = rate_q[0];
  assign y_rate    = rate_q[1];
  assign z_rate    = rate_q[2];
  assign x_angle   = angle_q[0];
  assign y_angle   = angle_q[1];
  assign z_angle   = angle_q[2];

endmodule

// File: tb/tb_gyro_axis_conditioner.sv
// Self-checking bench for gyro_axis_conditioner: integer reference model compared every cycle,
// plus hand-computed literal checks. Honours GYRO_ANGLE_WRAP_EN the same way as the design.
module tb_gyro_axis_conditioner;
  localparam int CAL_LOG2 = 2;
  localparam int DEADBAND = 2;
  localparam int ANGLE_W  = 16;
  localparam int NCAL     = 1 << CAL_LOG2;

  logic clk = 1'b0;
  logic rst, sv, rc, ac;
  logic signed [15:0] x_in, y_in, z_in;
  logic cal_done, out_valid;
  logic signed [15:0] x_rate, y_rate, z_rate;
  logic signed [ANGLE_W-1:0] x_angle, y_angle, z_angle;

  int n_cmp = 0;
  int n_fail = 0;

  gyro_axis_conditioner #(.CAL_LOG2(CAL_LOG2), .DEADBAND(DEADBAND), .ANGLE_W(ANGLE_W)) dut (
    .clk(clk), .rst(rst), .sample_valid(sv), .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .recal(rc), .angle_clr(ac), .cal_done(cal_done), .out_valid(out_valid),
    .x_rate(x_rate), .y_rate(y_rate), .z_rate(z_rate),
    .x_angle(x_angle), .y_angle(y_angle), .z_angle(z_angle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic.
  bit     m_init = 1'b0;
  bit     m_run, m_ov;
  int     m_cnt;
  int     m_sum [3];
  int     m_bias [3];
  int     m_rate [3];
  longint m_ang [3];

  function automatic int smp(input int i);
    if (i == 0) return int'(x_in);
    else if (i == 1) return int'(y_in);
    else return int'(z_in);
  endfunction

  task automatic model_step();
    longint lim;
    longint a;
    int d;
    lim = longint'(1) << (ANGLE_W - 1);
    if (!rst) begin
      m_init = 1'b1; m_run = 1'b0; m_ov = 1'b0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin
        m_sum[i] = 0; m_bias[i] = 0; m_rate[i] = 0; m_ang[i] = 0;
      end
    end else begin
      m_ov = 1'b0;
      if (rc) begin
        m_run = 1'b0; m_cnt = 0;
        for (int i = 0; i < 3; i++) m_sum[i] = 0;
      end else if (sv) begin
        if (!m_run) begin
          for (int i = 0; i < 3; i++) m_sum[i] += smp(i);
          m_cnt++;
          if (m_cnt == NCAL) begin
            for (int i = 0; i < 3; i++) begin
              m_bias[i] = m_sum[i] >>> CAL_LOG2;
              m_sum[i] = 0;
            end
            m_run = 1'b1; m_cnt = 0;
          end
        end else begin
          m_ov = 1'b1;
          for (int i = 0; i < 3; i++) begin
            d = smp(i) - m_bias[i];
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            if (d <= DEADBAND && d >= -DEADBAND) d = 0;
            m_rate[i] = d;
            a = m_ang[i] + d;
`ifdef GYRO_ANGLE_WRAP_EN
            if (a >= lim) a -= 2 * lim;
            if (a < -lim) a += 2 * lim;
`else
            if (a >= lim) a = lim - 1;
            if (a < -lim) a = -lim;
`endif
            m_ang[i] = a;
          end
        end
      end
      if (ac) for (int i = 0; i < 3; i++) m_ang[i] = 0;
    end
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("cal_done", longint'(cal_done), longint'(m_run));
      chk("out_valid", longint'(out_valid), longint'(m_ov));
      chk("x_rate", longint'(x_rate), longint'(m_rate[0]));
      chk("y_rate", longint'(y_rate), longint'(m_rate[1]));
      chk("z_rate", longint'(z_rate), longint'(m_rate[2]));
      chk("x_angle", longint'(x_angle), m_ang[0]);
      chk("y_angle", longint'(y_angle), m_ang[1]);
      chk("z_angle", longint'(z_angle), m_ang[2]);
    end
  end

  task automatic drive(input bit s, input bit r, input bit c, input int xv, input int yv, input int zv);
    sv = s; rc = r; ac = c;
    x_in = 16'(xv); y_in = 16'(yv); z_in = 16'(zv);
    @(posedge clk); #1;
    sv = 1'b0; rc = 1'b0; ac = 1'b0;
  endtask

  task automatic send(input int xv, input int yv, input int zv);
    drive(1'b1, 1'b0, 1'b0, xv, yv, zv);
  endtask

  initial begin
    rst = 1'b0; sv = 1'b0; rc = 1'b0; ac = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    // Reset held two cycles while samples toggle.
    @(posedge clk); #1; sv = 1'b1; x_in = 16'sd5;
    @(posedge clk); #1; sv = 1'b0;
    chk("rst_cal_done", longint'(cal_done), 0);
    chk("rst_x_angle", longint'(x_angle), 0);
    chk("rst_x_rate", longint'(x_rate), 0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("post_rst_out_valid", longint'(out_valid), 0);

    // Calibration: bias_x = 11, bias_y = bias_z = -3.
    send(10, -3, -3); send(12, -3, -3); send(10, -3, -3);
    chk("cal3_cal_done", longint'(cal_done), 0);
    send(12, -3, -3);
    chk("cal4_cal_done", longint'(cal_done), 1);
    chk("cal4_out_valid", longint'(out_valid), 0);

    send(21, -3, -3);
    chk("run1_out_valid", longint'(out_valid), 1);
    chk("run1_x_rate", longint'(x_rate), 10);
    chk("run1_x_angle", longint'(x_angle), 10);
    chk("run1_y_rate", longint'(y_rate), 0);
    send(13, -3, -3);
    chk("run2_x_rate", longint'(x_rate), 0);
    chk("run2_x_angle", longint'(x_angle), 10);
    send(8, -3, -3);
    chk("run3_x_rate", longint'(x_rate), -3);
    chk("run3_x_angle", longint'(x_angle), 7);

    // Recal with clear together, zero bias, then drive the angle into its limit.
    drive(1'b0, 1'b1, 1'b1, 0, 0, 0);
    chk("recal_cal_done", longint'(cal_done), 0);
    chk("recal_x_angle", longint'(x_angle), 0);
    chk("recal_x_rate_held", longint'(x_rate), -3);
    for (int k = 0; k < NCAL; k++) send(0, 0, 0);
    send(32767, 0, 0);
    chk("sat1_x_angle", longint'(x_angle), 32767);
    send(32767, 0, 0);
`ifdef GYRO_ANGLE_WRAP_EN
    chk("wrap2_x_angle", longint'(x_angle), -2);
`else
    chk("sat2_x_angle", longint'(x_angle), 32767);
`endif
    send(32767, 0, 0);
`ifndef GYRO_ANGLE_WRAP_EN
    chk("sat3_x_angle", longint'(x_angle), 32767);
`endif

    // Bias -100: a full-scale sample saturates the rate instead of wrapping.
    drive(1'b0, 1'b1, 1'b1, 0, 0, 0);
    for (int k = 0; k < NCAL; k++) send(-100, 0, 0);
    send(32767, 0, 0);
    chk("ratesat_x_rate", longint'(x_rate), 32767);
    chk("ratesat_x_angle", longint'(x_angle), 32767);
    send(50, 7, -9);
    chk("run_x_rate_150", longint'(x_rate), 150);

    // recal coinciding with a sample: sample dropped, outputs held.
    drive(1'b1, 1'b1, 1'b0, 1000, 1000, 1000);
    chk("recal_sv_out_valid", longint'(out_valid), 0);
    chk("recal_sv_cal_done", longint'(cal_done), 0);
    chk("recal_sv_x_rate", longint'(x_rate), 150);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 0);
    for (int k = 0; k < NCAL; k++) send(0, 0, 0);
    send(50, 7, -9);
    chk("clean_x_angle", longint'(x_angle), 50);
    chk("clean_z_angle", longint'(z_angle), -9);

    // angle_clr coinciding with a sample: angles zero, rates still update.
    drive(1'b1, 1'b0, 1'b1, -20, 3, 2);
    chk("clr_sv_out_valid", longint'(out_valid), 1);
    chk("clr_sv_x_angle", longint'(x_angle), 0);
    chk("clr_sv_x_rate", longint'(x_rate), -20);
    chk("clr_sv_y_rate", longint'(y_rate), 3);
    chk("clr_sv_z_rate", longint'(z_rate), 0);

    // Back-to-back samples around the deadband edges and negative full scale.
    send(-2, -3, 2); send(3, -32768, -3); send(-32768, 32767, 1);
    send(-32768, -32768, 0); send(-32768, -32768, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
